tsc_trigger_seq: RTL and testbench

- Trigger stage directly upstream of the key-leak side-channel block; sole source of its Tj_Trig input.
- Monitors the DES plaintext input bus and asserts Tj_Trig only after a fixed, rare sequence of SEQ_LEN plaintext blocks arrives in order on consecutive valid strobes.
- Emits a one-cycle trigger pulse, then enters a hold-off window in which re-triggering is blocked.
- Exists as an evaluation benchmark for trigger-detection and coverage tooling.

---
 rtl/tsc_pkg.sv | 25 ++
 rtl/tsc_holdoff_cnt.sv | 35 +++
 rtl/tsc_trigger_seq.sv | 102 ++++++++++
 tb/tb_tsc_trigger_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// rtl/tsc_pkg.sv - shared types and default constants for the trigger sequencer
// Purpose: state encoding of the trigger FSM, the default plaintext patterns
//          that form the trigger sequence, default hold-off length and
//          fire counter width.
// Ports:   none (package)
package tsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M1   = 3'd1,
    ST_M2   = 3'd2,
    ST_M3   = 3'd3,
    ST_FIRE = 3'd4,
    ST_HOLD = 3'd5
  } tsc_state_e;

  localparam int          TSC_DATA_W  = 64;
  localparam logic [63:0] TSC_P0      = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] TSC_P1      = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] TSC_P2      = 64'hA5A5_5A5A_A5A5_5A5A;
  localparam logic [63:0] TSC_P3      = 64'h0000_0000_DEAD_BEEF;
  localparam int          TSC_HOLDOFF = 16;
  localparam int          TSC_CNT_W   = 8;

endpackage

// File: rtl/tsc_holdoff_cnt.sv
// rtl/tsc_holdoff_cnt.sv - loadable down-counter with zero flag
// Purpose: times the re-trigger blocking window after a fire.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset (count clears to 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   W-bit value to load
//   dec      in   decrement by one
//   zero     out  count is zero
module tsc_holdoff_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/tsc_trigger_seq.sv
// rtl/tsc_trigger_seq.sv - ordered plaintext sequence trigger with hold-off
// Purpose: watches the plaintext bus and pulses Tj_Trig for one cycle after
//          P0,P1,P2,P3 arrive on consecutive valid strobes, then blocks
//          re-triggering for HOLDOFF cycles.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   data_in    in   DATA_W plaintext block
//   data_valid in   qualifies data_in
//   Tj_Trig    out  registered single-cycle trigger pulse
//   seq_state  out  current FSM state code
//   fire_count out  saturating count of trigger pulses
module tsc_trigger_seq
  import tsc_pkg::*;
#(
  parameter int                DATA_W  = TSC_DATA_W,
  parameter logic [DATA_W-1:0] P0      = TSC_P0,
  parameter logic [DATA_W-1:0] P1      = TSC_P1,
  parameter logic [DATA_W-1:0] P2      = TSC_P2,
  parameter logic [DATA_W-1:0] P3      = TSC_P3,
  parameter int                HOLDOFF = TSC_HOLDOFF,
  parameter int                CNT_W   = TSC_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              Tj_Trig,
  output logic [2:0]        seq_state,
  output logic [CNT_W-1:0]  fire_count
);

  // Counter only needs to hold HOLDOFF-1; keep at least one bit.
  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);

  tsc_state_e       state_q, state_d;
  logic             tj_q;
  logic [CNT_W-1:0] fire_q;
  logic             ho_load, ho_dec, ho_zero;

  tsc_holdoff_cnt #(.W(HO_W)) u_holdoff (
    .clk      (clk),
    .rst      (rst),
    .load     (ho_load),
    .load_val (HO_LOAD),
    .dec      (ho_dec),
    .zero     (ho_zero)
  );

  always_comb begin
    state_d = state_q;
    ho_load = 1'b0;
    ho_dec  = 1'b0;
    case (state_q)
      ST_IDLE: if (data_valid && data_in == P0) state_d = ST_M1;
      ST_M1: if (data_valid) begin
        if (data_in == P1)      state_d = ST_M2;
        else if (data_in == P0) state_d = ST_M1;
        else                    state_d = ST_IDLE;
      end
      ST_M2: if (data_valid) begin
        if (data_in == P2)      state_d = ST_M3;
        else if (data_in == P0) state_d = ST_M1;
        else                    state_d = ST_IDLE;
      end
      ST_M3: if (data_valid) begin
        if (data_in == P3)      state_d = ST_FIRE;
        else if (data_in == P0) state_d = ST_M1;
        else                    state_d = ST_IDLE;
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
        ho_load = 1'b1;
      end
      ST_HOLD: begin
        // data_in is deliberately ignored for the whole window.
        if (ho_zero) state_d = ST_IDLE;
        else         ho_dec  = 1'b1;
      end
      default: state_d = ST_IDLE;  // codes 6-7 recover
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tj_q    <= 1'b0;
      fire_q  <= '0;
    end else begin
      state_q <= state_d;
      // Registered copy of "entering FIRE": high exactly while in FIRE.
      tj_q    <= (state_d == ST_FIRE);
      if ((state_q == ST_FIRE) && !(&fire_q)) fire_q <= fire_q + 1'b1;
    end
  end

  assign Tj_Trig    = tj_q;
  assign seq_state  = state_q;
  assign fire_count = fire_q;

endmodule

// File: tb/tb_tsc_trigger_seq.sv
// tb/tb_tsc_trigger_seq.sv - self-checking bench for tsc_trigger_seq
module tb_tsc_trigger_seq;
  import tsc_pkg::*;

  localparam int HOLDOFF = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [63:0]      data_in = '0;
  logic             data_valid = 1'b0;
  logic             Tj_Trig;
  logic [2:0]       seq_state;
  logic [CNT_W-1:0] fire_count;

  int checks = 0;
  int errors = 0;

  tsc_trigger_seq #(
    .DATA_W (64), .P0 (TSC_P0), .P1 (TSC_P1), .P2 (TSC_P2), .P3 (TSC_P3),
    .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .Tj_Trig    (Tj_Trig),
    .seq_state  (seq_state),
    .fire_count (fire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i);
    case (i)
      0: return TSC_P0;
      1: return TSC_P1;
      2: return TSC_P2;
      default: return TSC_P3;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: matched-prefix length, pending fire, cycles of blocking left.
  int m_k = 0;
  int m_hold = 0;
  int m_fires = 0;
  bit m_fire = 1'b0;

  always @(negedge rst) begin
    m_k = 0; m_hold = 0; m_fires = 0; m_fire = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (m_fire) begin
        m_fire = 1'b0;
        if (m_fires < CNT_MAX) m_fires++;
        m_hold = HOLDOFF;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (data_valid) begin
        if (data_in == pat(m_k)) begin
          m_k++;
          if (m_k == 4) begin m_fire = 1'b1; m_k = 0; end
        end else if (data_in == TSC_P0) begin
          m_k = 1;
        end else begin
          m_k = 0;
        end
      end
    end
  end

  function automatic int exp_state();
    if (m_fire) return 4;
    if (m_hold > 0) return 5;
    return m_k;
  endfunction

  always @(negedge clk) begin
    check("seq_state", 64'(seq_state), 64'(exp_state()));
    check("Tj_Trig", 64'(Tj_Trig), 64'(m_fire));
    check("fire_count", 64'(fire_count), 64'(m_fires));
  end

  task automatic drive(input logic v, input logic [63:0] d);
    data_valid = v;
    data_in    = d;
    @(negedge clk);
  endtask

  task automatic send_seq();
    for (int i = 0; i < 4; i++) drive(1'b1, pat(i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_tj", 64'(Tj_Trig), 64'd0);
    check("reset_state", 64'(seq_state), 64'd0);
    check("reset_count", 64'(fire_count), 64'd0);
    rst = 1'b1;

    repeat (100) drive(1'b1, rnd64());
    check("idle_no_fire", 64'(fire_count), 64'd0);

    // Basic fire and hold-off length
    drive(1'b1, TSC_P0); check("basic_m1", 64'(seq_state), 64'd1);
    drive(1'b1, TSC_P1); check("basic_m2", 64'(seq_state), 64'd2);
    drive(1'b1, TSC_P2); check("basic_m3", 64'(seq_state), 64'd3);
    drive(1'b1, TSC_P3); check("basic_fire_state", 64'(seq_state), 64'd4);
    check("basic_tj", 64'(Tj_Trig), 64'd1);
    drive(1'b0, '0);
    check("basic_tj_drop", 64'(Tj_Trig), 64'd0);
    check("basic_count", 64'(fire_count), 64'd1);
    repeat (15) drive(1'b0, '0);
    check("hold_last", 64'(seq_state), 64'd5);
    drive(1'b0, '0);
    check("hold_exit", 64'(seq_state), 64'd0);

    // Gaps and restart
    drive(1'b1, TSC_P0);
    repeat (3) drive(1'b0, rnd64());
    check("gap_hold_m1", 64'(seq_state), 64'd1);
    drive(1'b1, TSC_P1);
    drive(1'b1, TSC_P0); check("restart_m1", 64'(seq_state), 64'd1);
    drive(1'b1, TSC_P1);
    drive(1'b1, TSC_P2);
    drive(1'b1, TSC_P3); check("restart_tj", 64'(Tj_Trig), 64'd1);
    repeat (17) drive(1'b0, '0);
    check("restart_count", 64'(fire_count), 64'd2);

    // Mismatch
    drive(1'b1, TSC_P0);
    drive(1'b1, TSC_P1);
    drive(1'b1, 64'h1); check("mismatch_idle", 64'(seq_state), 64'd0);
    drive(1'b1, TSC_P2);
    drive(1'b1, TSC_P3); check("mismatch_no_tj", 64'(Tj_Trig), 64'd0);
    check("mismatch_count", 64'(fire_count), 64'd2);

    // Hold-off blocking
    send_seq();
    send_seq();
    repeat (13) drive(1'b0, '0);
    check("holdoff_idle", 64'(seq_state), 64'd0);
    check("holdoff_count", 64'(fire_count), 64'd3);
    send_seq(); check("holdoff_refire", 64'(Tj_Trig), 64'd1);
    repeat (17) drive(1'b0, '0);
    check("holdoff_count2", 64'(fire_count), 64'd4);

    // Asynchronous reset in M3
    drive(1'b1, TSC_P0); drive(1'b1, TSC_P1); drive(1'b1, TSC_P2);
    data_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0; #1;
    check("async_m3_state", 64'(seq_state), 64'd0);
    check("async_m3_count", 64'(fire_count), 64'd0);
    @(negedge clk); rst = 1'b1;
    drive(1'b1, TSC_P3);
    check("p3_alone_no_tj", 64'(Tj_Trig), 64'd0);
    check("p3_alone_state", 64'(seq_state), 64'd0);

    // Asynchronous reset during HOLD
    send_seq();
    repeat (3) drive(1'b0, '0);
    @(posedge clk); #2 rst = 1'b0; #1;
    check("async_hold_count", 64'(fire_count), 64'd0);
    check("async_hold_state", 64'(seq_state), 64'd0);
    @(negedge clk); rst = 1'b1;

    // Randomized traffic, biased toward the pattern words
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 5);
      drive(1'($urandom_range(0, 3) != 0), (r < 4) ? pat(r) : rnd64());
    end
    repeat (20) drive(1'b0, '0);

    // Saturation
    for (int n = 0; n < 260; n++) begin
      send_seq();
      repeat (17) drive(1'b0, '0);
    end
    check("saturate", 64'(fire_count), 64'(CNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
